pipe_ctrl: RTL

Central pipeline control unit that drives the 6-bit `pause` vector and the flush lines consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates stage stall requests, branch redirects from EX and exception/ertn redirects from WB.
- Holds each redirect as a valid/ready request toward the fetch stage until fetch accepts it.
- Keeps wrong-path instructions out of IF/ID while a redirect is pending.
- Provides stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_perf.sv | 39 +++
 rtl/pipe_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: pause bit indices, pause
// encodings, redirect FSM state encoding and the default PC width.
package pipe_ctrl_pkg;

   localparam int PC_W_DEF = 32;

   localparam int PAUSE_PC  = 0;
   localparam int PAUSE_IF  = 1;
   localparam int PAUSE_ID  = 2;
   localparam int PAUSE_EX  = 3;
   localparam int PAUSE_MEM = 4;
   localparam int PAUSE_WB  = 5;

   localparam logic [5:0] PAUSE_NONE  = 6'b000000;
   localparam logic [5:0] PAUSE_BY_IF = 6'b000011;
   localparam logic [5:0] PAUSE_BY_ID = 6'b000111;
   localparam logic [5:0] PAUSE_BY_EX = 6'b001111;
   localparam logic [5:0] PAUSE_BY_MEM = 6'b011111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_REDIR = 1'b1;

   // The oldest stalled stage wins; it freezes itself and everything younger.
   function automatic logic [5:0] pause_encode(input logic s_if, input logic s_id,
                                               input logic s_ex, input logic s_mem);
      if (s_mem)     return PAUSE_BY_MEM;
      else if (s_ex) return PAUSE_BY_EX;
      else if (s_id) return PAUSE_BY_ID;
      else if (s_if) return PAUSE_BY_IF;
      else           return PAUSE_NONE;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters: stall cycles (wrapping) and accepted redirects
// (saturating at all-ones).
module pipe_ctrl_perf #(
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_tick,
   input  logic                   flush_tick,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic [FLUSH_CNT_W-1:0] flush_count
);

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

   logic [STALL_CNT_W-1:0] r_stall_cycles;
   logic [FLUSH_CNT_W-1:0] r_flush_count;
   logic                   w_flush_sat;

   assign w_flush_sat = &r_flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (stall_tick)
            r_stall_cycles <= r_stall_cycles + STALL_ONE;
         if (flush_tick && !w_flush_sat)
            r_flush_count <= r_flush_count + FLUSH_ONE;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall-to-pause encoding, branch/exception redirect
// arbitration and the registered valid/ready redirect toward fetch.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W        = PC_W_DEF,
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_req_if,
   input  logic                   stall_req_id,
   input  logic                   stall_req_ex,
   input  logic                   stall_req_mem,
   input  logic                   branch_req,
   input  logic [PC_W-1:0]        branch_pc,
   input  logic                   exc_req,
   input  logic [PC_W-1:0]        exc_pc,
   output logic [5:0]             pause,
   output logic                   branch_flush,
   output logic                   flush,
   output logic                   redirect_valid,
   output logic [PC_W-1:0]        redirect_pc,
   input  logic                   redirect_ready,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic [FLUSH_CNT_W-1:0] flush_count,
   output logic [0:0]             o_dbg_state
);

   // Handshake: redirect_valid/redirect_pc come straight from registers and
   // hold until a cycle with redirect_valid && redirect_ready; an exception
   // accepted in that same cycle replaces the target and the handshake is void.

   logic [0:0]      r_state;
   logic [PC_W-1:0] r_redirect_pc;
   logic [5:0]      w_stall_pause;
   logic            w_exc_acc;
   logic            w_br_acc;
   logic            w_in_redir;

   always_comb begin
      w_stall_pause = pause_encode(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
      w_in_redir    = (r_state == ST_REDIR);
      w_exc_acc     = !rst && exc_req;
      // EX frozen means the branch instruction is still there next cycle.
      w_br_acc      = !rst && branch_req && !exc_req && !w_stall_pause[PAUSE_EX] && !w_in_redir;
   end

   assign pause        = (rst || exc_req) ? PAUSE_NONE : w_stall_pause;
   assign flush        = w_exc_acc;
   assign branch_flush = w_exc_acc || w_br_acc || (!rst && w_in_redir);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_redirect_pc <= '0;
      end else if (w_exc_acc) begin
         r_state       <= ST_REDIR;
         r_redirect_pc <= exc_pc;
      end else if (w_br_acc) begin
         r_state       <= ST_REDIR;
         r_redirect_pc <= branch_pc;
      end else if (w_in_redir && redirect_ready) begin
         r_state       <= ST_IDLE;
      end
   end

   assign redirect_valid = w_in_redir;
   assign redirect_pc    = r_redirect_pc;
   assign o_dbg_state    = r_state;

   pipe_ctrl_perf #(
      .STALL_CNT_W (STALL_CNT_W),
      .FLUSH_CNT_W (FLUSH_CNT_W)
   ) u_perf (
      .clk          (clk),
      .rst          (rst),
      .stall_tick   (pause[PAUSE_PC]),
      .flush_tick   (w_exc_acc || w_br_acc),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

endmodule
